// File: rtl/parking_meter_pkg.sv
// Shared types and constants for the parking meter bank: status encoding,
// button increment/preset tables and a clamp helper.
package parking_meter_pkg;

    typedef enum logic [1:0] {
        ST_EXPIRED = 2'd0,
        ST_LOW     = 2'd1,
        ST_OK      = 2'd2,
        ST_GRACE   = 2'd3
    } meter_state_e;

    localparam int unsigned ADD_VALS    [4] = '{60, 120, 180, 300};
    localparam int unsigned PRESET_VALS [2] = '{15, 150};

    function automatic int unsigned clamp_time(input int unsigned v, input int unsigned max_t);
        return (v > max_t) ? max_t : v;
    endfunction

endpackage

// File: rtl/parking_meter_channel.sv
// One meter: saturating seconds counter plus its status FSM.
// Optional grace period after expiry is built in when METER_GRACE_EN is defined.
module parking_meter_channel
    import parking_meter_pkg::*;
#(
    parameter int MAX_TIME   = 9999,
    parameter int LOW_THRESH = 180,
`ifdef METER_GRACE_EN
    parameter int GRACE_SEC  = 10,
`endif
    parameter int W          = $clog2(MAX_TIME + 1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         tick_i,
    input  logic         btn_i,
    input  logic         load_i,
    input  logic [W-1:0] val_i,
    output logic [W-1:0] cnt_o,
    output meter_state_e state_o
);

    localparam logic [W:0]   MAX_EXT = (W+1)'(MAX_TIME);
    localparam logic [W-1:0] LOW_W   = W'(LOW_THRESH);

    logic [W-1:0] cnt_q, cnt_d;
    meter_state_e state_q, state_d;

    function automatic logic [W-1:0] sat_add(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return (sum > MAX_EXT) ? MAX_EXT[W-1:0] : sum[W-1:0];
    endfunction

    function automatic meter_state_e classify(input logic [W-1:0] t);
        if (t == '0)
            return ST_EXPIRED;
        else if (t < LOW_W)
            return ST_LOW;
        else
            return ST_OK;
    endfunction

    // A button on this channel wins over the tick: no decrement that cycle.
    always_comb begin
        cnt_d = cnt_q;
        if (btn_i)
            cnt_d = load_i ? val_i : sat_add(cnt_q, val_i);
        else if (tick_i && cnt_q != '0)
            cnt_d = cnt_q - W'(1);
    end

`ifdef METER_GRACE_EN
    localparam int GW = (GRACE_SEC > 1) ? $clog2(GRACE_SEC) : 1;
    localparam logic [GW-1:0] GRACE_LAST = GW'(GRACE_SEC - 1);

    logic [GW-1:0] grace_q, grace_d;

    always_comb begin
        state_d = classify(cnt_d);
        grace_d = grace_q;
        if (state_q == ST_GRACE && !btn_i) begin
            state_d = ST_GRACE;
            if (tick_i) begin
                if (grace_q == GRACE_LAST)
                    state_d = ST_EXPIRED;
                else
                    grace_d = grace_q + GW'(1);
            end
        end else if (state_q == ST_LOW && cnt_d == '0) begin
            state_d = ST_GRACE;
            grace_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            grace_q <= '0;
        else
            grace_q <= grace_d;
    end
`else
    always_comb begin
        state_d = classify(cnt_d);
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            state_q <= ST_EXPIRED;
        end else begin
            cnt_q   <= cnt_d;
            state_q <= state_d;
        end
    end

    assign cnt_o   = cnt_q;
    assign state_o = state_q;

endmodule

// File: rtl/parking_meter_bank.sv
// NCH parking meters sharing a 1 Hz divider, one button set steered by ch_sel,
// and a display-blank generator. Define METER_GRACE_EN for the post-expiry grace period.
module parking_meter_bank
    import parking_meter_pkg::*;
#(
    parameter int  CLK_HZ     = 100,
    parameter int  NCH        = 4,
    parameter int  MAX_TIME   = 9999,
    parameter int  LOW_THRESH = 180,
    parameter int  GRACE_SEC  = 10,
    localparam int W          = $clog2(MAX_TIME + 1),
    localparam int SW         = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [SW-1:0]  ch_sel,
    input  logic [3:0]     add,
    input  logic [1:0]     preset,
    output logic [W-1:0]   time_out,
    output logic [1:0]     state_out,
    output logic           blank,
    output logic [NCH-1:0] expired,
    output logic           tick
);

    localparam int DW = $clog2(CLK_HZ);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_HZ - 1);
    localparam logic [DW-1:0] HALF     = DW'(CLK_HZ / 2);

    if (CLK_HZ < 2 || (CLK_HZ % 2) != 0 || NCH < 1 || NCH > 16 ||
        MAX_TIME < 1 || GRACE_SEC < 1) begin : g_bad_cfg
        $error("parking_meter_bank: unsupported parameter set");
    end

    logic [DW-1:0] div_q, div_d;
    logic [3:0]    add_q, add_press;
    logic [1:0]    preset_q, preset_press;
    logic          act, act_load;
    logic [W-1:0]  act_val;
    logic          blank_q, blank_d;
    logic [W-1:0]  cnt_a [NCH];
    meter_state_e  st_a  [NCH];
    meter_state_e  sel_state;

    assign tick         = (div_q == DIV_LAST);
    assign div_d        = tick ? '0 : div_q + DW'(1);
    assign add_press    = add & ~add_q;
    assign preset_press = preset & ~preset_q;

    // Later assignments win, so the loops run from lowest to highest priority.
    always_comb begin
        act      = 1'b0;
        act_load = 1'b0;
        act_val  = '0;
        for (int i = 1; i >= 0; i--) begin
            if (preset_press[i]) begin
                act      = 1'b1;
                act_load = 1'b1;
                act_val  = W'(clamp_time(PRESET_VALS[i], MAX_TIME));
            end
        end
        for (int i = 3; i >= 0; i--) begin
            if (add_press[i]) begin
                act      = 1'b1;
                act_load = 1'b0;
                act_val  = W'(clamp_time(ADD_VALS[i], MAX_TIME));
            end
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        parking_meter_channel #(
            .MAX_TIME   (MAX_TIME),
            .LOW_THRESH (LOW_THRESH),
`ifdef METER_GRACE_EN
            .GRACE_SEC  (GRACE_SEC),
`endif
            .W          (W)
        ) u_ch (
            .clk     (clk),
            .rst     (rst),
            .tick_i  (tick),
            .btn_i   (act && (ch_sel == SW'(i))),
            .load_i  (act_load),
            .val_i   (act_val),
            .cnt_o   (cnt_a[i]),
            .state_o (st_a[i])
        );
        assign expired[i] = (st_a[i] == ST_EXPIRED);
    end

    // Out-of-range selects read as an expired, empty meter.
    always_comb begin
        time_out  = '0;
        sel_state = ST_EXPIRED;
        for (int i = 0; i < NCH; i++) begin
            if (ch_sel == SW'(i)) begin
                time_out  = cnt_a[i];
                sel_state = st_a[i];
            end
        end
    end

    assign state_out = sel_state;

`ifdef METER_GRACE_EN
    localparam logic [DW-1:0] QUARTER = DW'(CLK_HZ / 4);
    logic [DW-1:0] phase;
    assign phase = (div_q >= HALF) ? div_q - HALF : div_q;
`endif

    always_comb begin
        blank_d = 1'b0;
        case (sel_state)
            ST_EXPIRED: blank_d = (div_q >= HALF);
            ST_LOW:     blank_d = (div_q >= HALF) && !time_out[0];
`ifdef METER_GRACE_EN
            ST_GRACE:   blank_d = (phase >= QUARTER);
`endif
            default:    blank_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q    <= '0;
            add_q    <= '0;
            preset_q <= '0;
            blank_q  <= 1'b0;
        end else begin
            div_q    <= div_d;
            add_q    <= add;
            preset_q <= preset;
            blank_q  <= blank_d;
        end
    end

    assign blank = blank_q;

endmodule
